// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// States, default opcode width and operand-B mux select encodings.
package alu_arb_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int OPW_DEF   = 4;
    localparam int CNT_W     = 4;

    localparam logic ALU_SRC_REG = 1'b0;
    localparam logic ALU_SRC_IMM = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_port_arbiter_if.sv
// Request, ALU and response bundle between issue logic, arbiter and execute-stage ALU.
// master = surrounding issue/ALU/consumer logic, slave = the arbiter.
interface alu_port_arbiter_if
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
);

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_imm;
    logic [OPW-1:0]   req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_data0;
    logic [WIDTH-1:0] alu_data1;
    logic             alu_src;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_result;

    logic [WIDTH-1:0] rsp_data;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic             rsp_ready;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_imm, req1_op,
        input  req1_ready,
        input  alu_a, alu_data0, alu_data1, alu_src, alu_op,
        output alu_result,
        input  rsp_data, rsp0_valid, rsp1_valid,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_imm, req1_op,
        output req1_ready,
        output alu_a, alu_data0, alu_data1, alu_src, alu_op,
        input  alu_result,
        output rsp_data, rsp0_valid, rsp1_valid,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_port_arbiter_rr_arb2.sv
// Two-input grant: round-robin with a 1-bit pointer, or fixed port-0 priority under ALU_ARB_FIXED_PRI_EN.
// Latency: grant is combinational on req; pointer moves on the cycle a grant is accepted.
// Backpressure: pointer only advances when the caller signals adv (grant actually taken).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRI_EN
    logic unused_ok;

    assign unused_ok = clk ^ rst_n ^ adv;
    assign gnt       = {req[1] & ~req[0], req[0]};
`else
    // ptr == 0 favours port 0 on contention, ptr == 1 favours port 1
    logic ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (adv) begin
            ptr <= gnt[0];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !ptr)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/alu_port_arbiter.sv
// Shares one ALU between a reg-reg port (0) and a reg-imm port (1); ALU_ARB_FIXED_PRI_EN selects fixed priority.
// Latency: accept in T, ALU operands from T+1, response valid from T+1+ALU_LAT.
// Backpressure: one op in flight; req_ready only in IDLE, response held until rsp_ready.
module alu_port_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int OPW     = OPW_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] data0_q;
    logic [WIDTH-1:0] data1_q;
    logic [WIDTH-1:0] res_q;
    logic [OPW-1:0]   op_q;
    logic             src_q;

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             idle;
    logic             accept;
    logic             exec_done;

    assign idle      = (state == IDLE);
    assign req       = {bus.req1_valid, bus.req0_valid};
    assign accept    = idle & (|gnt);
    assign exec_done = (state == EXEC) && (cnt == '0);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .adv   (accept),
        .gnt   (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)        state_nxt = EXEC;
            EXEC:    if (cnt == '0)     state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Unselected mux leg is zeroed so the ALU never sees stale data from the other port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            data0_q <= '0;
            data1_q <= '0;
            op_q    <= '0;
            src_q   <= ALU_SRC_REG;
            cnt     <= '0;
        end else if (accept) begin
            cnt <= CNT_INIT;
            if (gnt[1]) begin
                a_q     <= bus.req1_a;
                data0_q <= '0;
                data1_q <= bus.req1_imm;
                op_q    <= bus.req1_op;
                src_q   <= ALU_SRC_IMM;
            end else begin
                a_q     <= bus.req0_a;
                data0_q <= bus.req0_b;
                data1_q <= '0;
                op_q    <= bus.req0_op;
                src_q   <= ALU_SRC_REG;
            end
        end else if ((state == EXEC) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (exec_done) begin
            res_q <= bus.alu_result;
        end
    end

    assign bus.req0_ready = idle & gnt[0];
    assign bus.req1_ready = idle & gnt[1];

    assign bus.alu_a      = a_q;
    assign bus.alu_data0  = data0_q;
    assign bus.alu_data1  = data1_q;
    assign bus.alu_src    = src_q;
    assign bus.alu_op     = op_q;

    assign bus.rsp_data   = res_q;
    assign bus.rsp0_valid = (state == RESP) && (src_q == ALU_SRC_REG);
    assign bus.rsp1_valid = (state == RESP) && (src_q == ALU_SRC_IMM);

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Bench for alu_port_arbiter: pipelined ALU stand-in, transaction-level reference model, directed + random traffic.
module tb_alu_port_arbiter;

    localparam int L   = 3;
    localparam int PI  = (L > 1) ? L - 2 : 0;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int failures = 0;

    alu_port_arbiter_if #(.WIDTH(32), .OPW(4)) bus ();

    alu_port_arbiter #(.WIDTH(32), .OPW(4), .ALU_LAT(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // ALU stand-in: result appears L cycles after operands are presented.
    logic [31:0] comb0;
    logic [31:0] pipe [0:14];
    assign comb0 = alu_f(bus.alu_a, bus.alu_src ? bus.alu_data1 : bus.alu_data0, bus.alu_op);
    always @(posedge clk) begin
        pipe[0] <= comb0;
        for (int i = 1; i < 15; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.alu_result = (L == 1) ? comb0 : pipe[PI];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: one op in flight, timed from its acceptance cycle.
    int          cyc = 0;
    int          m_tacc = 0;
    bit          m_busy = 0;
    bit          m_ptr = 0;
    logic [31:0] m_a = 0, m_d0 = 0, m_d1 = 0, m_res = 0, m_new = 0;
    logic [3:0]  m_op = 0;
    bit          m_src = 0;
    bit          v0, v1, e_r0, e_r1, in_resp, g;
    int          grant_log[$];
    logic [31:0] rsp_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_ptr = 0; m_a = 0; m_d0 = 0; m_d1 = 0;
                m_op = 0; m_src = 0; m_res = 0; m_new = 0;
            end
            v0 = bus.req0_valid;
            v1 = bus.req1_valid;
`ifdef ALU_ARB_FIXED_PRI_EN
            e_r0 = !m_busy && v0;
            e_r1 = !m_busy && v1 && !v0;
`else
            e_r0 = !m_busy && v0 && (!v1 || !m_ptr);
            e_r1 = !m_busy && v1 && (!v0 || m_ptr);
`endif
            in_resp = m_busy && (cyc >= m_tacc + 1 + L);
            chk("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
            chk("alu_a",      bus.alu_a, m_a);
            chk("alu_data0",  bus.alu_data0, m_d0);
            chk("alu_data1",  bus.alu_data1, m_d1);
            chk("alu_src",    32'(bus.alu_src), 32'(m_src));
            chk("alu_op",     32'(bus.alu_op), 32'(m_op));
            chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(in_resp && !m_src));
            chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(in_resp && m_src));
            chk("rsp_data",   bus.rsp_data, in_resp ? m_new : m_res);
            if (rst_n) begin
                if (in_resp && bus.rsp_ready) begin
                    rsp_log.push_back(bus.rsp_data);
                    m_res  = m_new;
                    m_busy = 0;
                end else if (e_r0 || e_r1) begin
                    g      = e_r1;
                    m_src  = g;
                    m_a    = g ? bus.req1_a : bus.req0_a;
                    m_d0   = g ? 32'd0 : bus.req0_b;
                    m_d1   = g ? bus.req1_imm : 32'd0;
                    m_op   = g ? bus.req1_op : bus.req0_op;
                    m_new  = alu_f(m_a, g ? m_d1 : m_d0, m_op);
                    m_ptr  = !g;
                    m_busy = 1;
                    m_tacc = cyc;
                    grant_log.push_back(int'(g));
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_until_accept(input int port, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int base;
        bit done;
        base = grant_log.size();
        done = 0;
        if (port == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_imm = b; bus.req1_op = op; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (grant_log.size() > base) done = 1;
        end
        if (port == 0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
        chk("accept_count", 32'(grant_log.size()), 32'(base + 1));
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 200 && rsp_log.size() < n; i++) tick();
        chk("rsp_count", 32'(rsp_log.size()), 32'(n));
    endtask

    task automatic wait_grants(input int n);
        for (int i = 0; i < 200 && grant_log.size() < n; i++) tick();
        chk("grant_count", 32'(grant_log.size()), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int nr, ng;
        bit hs0, hs1;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_imm = 0; bus.req1_op = 0;
        bus.rsp_ready = 0;

        // Reset state: readies follow valid in IDLE, everything else zero.
        repeat (3) tick();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        chk("rst_req0_ready", 32'(bus.req0_ready), 32'd1);
        chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Port 0 alone: 5 + 7.
        bus.rsp_ready = 1'b1;
        nr = rsp_log.size();
        drive_until_accept(0, 32'd5, 32'd7, OP_ADD);
        chk("p0_alu_src", 32'(bus.alu_src), 32'd0);
        chk("p0_alu_data0", bus.alu_data0, 32'd7);
        chk("p0_alu_data1", bus.alu_data1, 32'd0);
        wait_rsp(nr + 1);
        chk("p0_result", rsp_log[nr], 32'd12);

        // Port 1 alone: 0x10 + 0xFFFFFFFF.
        nr = rsp_log.size();
        drive_until_accept(1, 32'h10, 32'hFFFF_FFFF, OP_ADD);
        chk("p1_alu_src", 32'(bus.alu_src), 32'd1);
        chk("p1_alu_data1", bus.alu_data1, 32'hFFFF_FFFF);
        chk("p1_alu_data0", bus.alu_data0, 32'd0);
        wait_rsp(nr + 1);
        chk("p1_result", rsp_log[nr], 32'h0000_000F);

        // Response stall: 100 - 23 held for 5 cycles while port 0 waits.
        bus.rsp_ready = 1'b0;
        nr = rsp_log.size();
        drive_until_accept(1, 32'd100, 32'd23, OP_SUB);
        bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_op = OP_ADD; bus.req0_valid = 1'b1;
        for (int i = 0; i < 20 && !bus.rsp1_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
            chk("stall_rsp_data", bus.rsp_data, 32'd77);
            chk("stall_req0_ready", 32'(bus.req0_ready), 32'd0);
            tick();
        end
        ng = grant_log.size();
        bus.rsp_ready = 1'b1;
        wait_grants(ng + 1);
        bus.req0_valid = 1'b0;
        chk("stall_next_grant", 32'(grant_log[ng]), 32'd0);
        wait_rsp(nr + 2);
        chk("stall_first_rsp", rsp_log[nr], 32'd77);
        chk("stall_second_rsp", rsp_log[nr + 1], 32'd3);

        // Reset during EXEC: op discarded, pointer returns to port 0.
        nr = rsp_log.size();
        drive_until_accept(0, 32'd3, 32'd4, OP_ADD);
        #1 rst_n = 1'b0;
        #1;
        chk("rstx_alu_a", bus.alu_a, 32'd0);
        chk("rstx_alu_data0", bus.alu_data0, 32'd0);
        chk("rstx_alu_op", 32'(bus.alu_op), 32'd0);
        chk("rstx_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Continuous contention for 4 ops.
        ng = grant_log.size();
        bus.req0_a = 32'd9; bus.req0_b = 32'd1; bus.req0_op = OP_ADD;
        bus.req1_a = 32'd9; bus.req1_imm = 32'd2; bus.req1_op = OP_SUB;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        wait_grants(ng + 4);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_rsp(nr + 4);
        repeat (20) tick();
        chk("rstx_no_extra_rsp", 32'(rsp_log.size()), 32'(nr + 4));
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
            chk("contend_grant", 32'(grant_log[ng + i]), 32'd0);
            chk("contend_rsp", rsp_log[nr + i], 32'd10);
`else
            chk("contend_grant", 32'(grant_log[ng + i]), 32'(i % 2));
            chk("contend_rsp", rsp_log[nr + i], (i % 2 == 0) ? 32'd10 : 32'd7);
`endif
        end

        // Random traffic: payload held until accepted, occasional legal drops.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs0 = bus.req0_valid & bus.req0_ready;
            hs1 = bus.req1_valid & bus.req1_ready;
            @(posedge clk);
            #1;
            if (!bus.req0_valid || hs0) begin
                bus.req0_valid = ($urandom_range(0, 2) == 0);
                bus.req0_a  = $urandom;
                bus.req0_b  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                bus.req0_op = 4'($urandom_range(0, 7));
            end else if ($urandom_range(0, 19) == 0) begin
                bus.req0_valid = 1'b0;
            end
            if (!bus.req1_valid || hs1) begin
                bus.req1_valid = ($urandom_range(0, 2) == 0);
                bus.req1_a   = $urandom;
                bus.req1_imm = $urandom_range(0, 4095);
                bus.req1_op  = 4'($urandom_range(0, 7));
            end else if ($urandom_range(0, 19) == 0) begin
                bus.req1_valid = 1'b0;
            end
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        repeat (30) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_port_arbiter.md
# alu_port_arbiter

Sequencer and arbiter that shares one 32-bit ALU between two requesters: port 0 issues register-register operations (ALU B operand from register data), port 1 issues register-immediate operations (ALU B operand from an immediate). The block grants one requester at a time, latches its operands, drives the ALU operand-B 2:1 mux select and the ALU opcode, waits the ALU latency, captures the result and returns it over a valid/ready response handshake. It sits between the issue logic and the execute stage's ALU and operand-B mux.

## Interface
- WIDTH, 32, datapath width
- OPW, 4, ALU opcode width
- ALU_LAT, 1, ALU cycles from operand presentation to result valid (legal 1..15)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req0_ready  in / out  1  port 0 request handshake
- req0_a, req0_b  in  WIDTH  port 0 operands A and B (register)
- req0_op  in  OPW  port 0 opcode
- req1_valid / req1_ready  in / out  1  port 1 request handshake
- req1_a, req1_imm  in  WIDTH  port 1 operand A and immediate
- req1_op  in  OPW  port 1 opcode
- alu_a  out  WIDTH  ALU operand A
- alu_data0, alu_data1  out  WIDTH  operand-B mux inputs (register, immediate)
- alu_src  out  1  operand-B mux select: 0 = alu_data0, 1 = alu_data1
- alu_op  out  OPW  ALU opcode
- alu_result  in  WIDTH  ALU result
- rsp_data  out  WIDTH  captured result
- rsp0_valid, rsp1_valid  out  1  result valid for port 0 / port 1
- rsp_ready  in  1  consumer accepts current response

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: arbitrate among asserted req*_valid; assert req_ready only to the winner (combinational on valid and state). Handshake (valid & ready) latches a, b-or-imm, op, grant id; alu_src ← grant id; the non-selected mux input is loaded with 0; go EXEC; load latency counter with ALU_LAT-1.
- EXEC: ALU inputs held stable from registers. Counter decrements each cycle; at count 0 rsp_data ← alu_result, go RESP.
- RESP: rspN_valid asserted for granted port only, rsp_data stable; on rsp_ready go IDLE. Both req_ready low outside IDLE.
- Arbitration: round-robin, 1-bit pointer; on each grant the pointer points to the other port. Single requester always wins regardless of pointer.
- Requester must hold valid and payload until ready; dropping valid before grant is legal and ignored.
- No arithmetic inside the block; results passed through unmodified.

## Timing
- Reset (async assert, sync release): state IDLE, pointer favours port 0, all data/opcode outputs 0, alu_src 0, rsp*_valid 0, req*_ready depend only on valid (IDLE).
- Request accepted in cycle T → alu_* driven from T+1 → rsp valid from T+1+ALU_LAT.
- Minimum issue interval ALU_LAT+2 cycles (rsp_ready held high).
- Simultaneous valids in IDLE: pointer decides; back-to-back contention strictly alternates 0,1,0,1.
- rsp_ready asserted in IDLE/EXEC: ignored.
- Reset mid-EXEC or mid-RESP: operation discarded, no response emitted.

## Configuration
- ALU_ARB_FIXED_PRI_EN defined: port 0 always wins simultaneous requests; pointer logic removed.
- Undefined (default): round-robin as above.

## Structure
- Package alu_arb_pkg: state enum (IDLE, EXEC, RESP), OPW default, ALU_SRC_REG = 0 / ALU_SRC_IMM = 1 constants.
- Sub-module rr_arb2: two-input round-robin grant with pointer register (fixed-priority under the macro).
- Top holds FSM, operand/result registers, latency counter.

## Test plan
- Port 0 alone, a=5, b=7, op=ADD, ALU_LAT=1, rsp_ready=1 → alu_src=0, alu_data0=7, alu_data1=0, rsp0_valid at T+2 with rsp_data=12; req0_ready only in IDLE.
- Port 1 alone, a=0x10, imm=0xFFFFFFFF, op=ADD → alu_src=1, alu_data1=0xFFFFFFFF, rsp1_valid with rsp_data=0x0000000F.
- Both valid continuously for 4 ops → grants 0,1,0,1; with ALU_FIXED macro (ALU_ARB_FIXED_PRI_EN) → 0,0,0,0.
- ALU_LAT=3, rsp_ready low 5 cycles in RESP → rsp_data, rsp1_valid held stable, req*_ready low, no new grant until rsp_ready.
- rst_n pulsed low during EXEC → outputs 0 immediately, no response, next request accepted normally with pointer at port 0.
